// File: rtl/sd_sector_arbiter_if.sv
// sd_sector_arbiter_if: requester, engine and word-steering signals of the SD sector arbiter
interface sd_sector_arbiter_if;
    logic        req0;
    logic [31:0] sec0;
    logic [11:0] num0;
    logic        ack0;
    logic        done0;
    logic        req1;
    logic [31:0] sec1;
    logic [11:0] num1;
    logic        ack1;
    logic        done1;
    logic        eng_ready;
    logic        eng_start;
    logic [31:0] eng_sec;
    logic        eng_valid;
    logic [31:0] eng_data;
    logic        eng_done;
    logic [31:0] data_o;
    logic        valid0_o;
    logic        valid1_o;
    logic        err_o;
    logic        busy_o;

    // arbiter side
    modport slave (
        input  req0, sec0, num0, req1, sec1, num1,
        input  eng_ready, eng_valid, eng_data, eng_done,
        output ack0, done0, ack1, done1,
        output eng_start, eng_sec, data_o, valid0_o, valid1_o, err_o, busy_o
    );

    // requester and engine side
    modport master (
        output req0, sec0, num0, req1, sec1, num1,
        output eng_ready, eng_valid, eng_data, eng_done,
        input  ack0, done0, ack1, done1,
        input  eng_start, eng_sec, data_o, valid0_o, valid1_o, err_o, busy_o
    );
endinterface

// File: rtl/sd_sector_arbiter.sv
// sd_sector_arbiter: run-granular round-robin sharing of a single-sector SD read engine between two requesters
// Optional sector watchdog enabled by defining SD_ARB_TIMEOUT_EN.
module sd_sector_arbiter #(
    parameter int WORDS_PER_SEC = 128,
    parameter int MAX_RETRY     = 3
`ifdef SD_ARB_TIMEOUT_EN
    ,
    parameter logic [23:0] TIMEOUT = 24'd4000000
`endif
) (
    input logic              SD_clk,
    input logic              init,
    sd_sector_arbiter_if.slave io_arb
);
    localparam int WW = $clog2(WORDS_PER_SEC + 2);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [WW-1:0] L_WPS  = WW'(WORDS_PER_SEC);
    localparam logic [WW-1:0] L_WSAT = WW'(WORDS_PER_SEC + 1);
    localparam logic [RW-1:0] L_MAXR = RW'(MAX_RETRY);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    logic [2:0]    r_state;
    logic          r_last_grant;
    logic          r_owner;
    logic [31:0]   r_cur_sec;
    logic [11:0]   r_remaining;
    logic [RW-1:0] r_retry;
    logic [WW-1:0] r_wcnt;
    logic          r_ack0;
    logic          r_ack1;
    logic          r_done0;
    logic          r_done1;
    logic          r_eng_start;
    logic [31:0]   r_eng_sec;
    logic [31:0]   r_data;
    logic          r_valid0;
    logic          r_valid1;
    logic          r_err;

    logic          w_gnt0;
    logic          w_gnt1;
    logic [11:0]   w_num;
    logic [WW-1:0] w_wcnt_inc;
    logic          w_word;
    logic          w_tout;
    logic          w_sec_ok;

    // requester 0 wins unless requester 1 also asks and 0 was served last
    always_comb begin
        w_gnt0     = io_arb.req0 && (!io_arb.req1 || r_last_grant);
        w_gnt1     = io_arb.req1 && !w_gnt0;
        w_num      = w_gnt1 ? io_arb.num1 : io_arb.num0;
        w_word     = (r_state == S_WAIT) && io_arb.eng_valid;
        w_wcnt_inc = (r_wcnt == L_WSAT) ? r_wcnt : r_wcnt + 1'b1;
        w_sec_ok   = (r_wcnt == L_WPS) && !w_tout;
    end

`ifdef SD_ARB_TIMEOUT_EN
    logic [23:0] r_tmr;
    logic        r_tout;

    assign w_tout = r_tout;

    // sector watchdog: restarted by each engine start, forces a short-count verdict when it expires
    always_ff @(posedge SD_clk or negedge init) begin
        if (!init) begin
            r_tmr  <= '0;
            r_tout <= 1'b0;
        end else if (r_state == S_ISSUE) begin
            r_tmr  <= '0;
            r_tout <= 1'b0;
        end else if (r_state == S_WAIT && !io_arb.eng_done) begin
            r_tmr  <= r_tmr + 24'd1;
            r_tout <= (r_tmr == TIMEOUT - 24'd1);
        end
    end
`else
    assign w_tout = 1'b0;
`endif

    // run sequencing: grant, issue each sector, verify its word count, retry or abort, report
    always_ff @(posedge SD_clk or negedge init) begin
        if (!init) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_cur_sec    <= '0;
            r_remaining  <= '0;
            r_retry      <= '0;
            r_wcnt       <= '0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_eng_start  <= 1'b0;
            r_eng_sec    <= '0;
            r_err        <= 1'b0;
        end else begin
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_eng_start <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_ack0       <= w_gnt0;
                        r_ack1       <= w_gnt1;
                        r_owner      <= w_gnt1;
                        r_last_grant <= w_gnt1;
                        r_cur_sec    <= w_gnt1 ? io_arb.sec1 : io_arb.sec0;
                        r_remaining  <= w_num;
                        r_retry      <= '0;
                        r_state      <= (w_num == 12'd0) ? S_FINISH : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (io_arb.eng_ready) begin
                        r_eng_start <= 1'b1;
                        r_eng_sec   <= r_cur_sec;
                        r_wcnt      <= '0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (io_arb.eng_valid)
                        r_wcnt <= w_wcnt_inc;
                    if (io_arb.eng_done || w_tout)
                        r_state <= S_CHECK;
                end
                S_CHECK: begin
                    if (w_sec_ok) begin
                        r_cur_sec   <= r_cur_sec + 32'd1;
                        r_remaining <= r_remaining - 12'd1;
                        r_retry     <= '0;
                        r_state     <= (r_remaining == 12'd1) ? S_FINISH : S_ISSUE;
                    end else if (r_retry < L_MAXR) begin
                        r_retry <= r_retry + 1'b1;
                        r_state <= S_ISSUE;
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_done0 <= !r_owner;
                    r_done1 <= r_owner;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // word steering: one-cycle registered copy of engine words, flagged for the run owner only
    always_ff @(posedge SD_clk or negedge init) begin
        if (!init) begin
            r_data   <= '0;
            r_valid0 <= 1'b0;
            r_valid1 <= 1'b0;
        end else begin
            r_valid0 <= w_word && !r_owner;
            r_valid1 <= w_word && r_owner;
            if (w_word)
                r_data <= io_arb.eng_data;
        end
    end

    assign io_arb.ack0      = r_ack0;
    assign io_arb.ack1      = r_ack1;
    assign io_arb.done0     = r_done0;
    assign io_arb.done1     = r_done1;
    assign io_arb.eng_start = r_eng_start;
    assign io_arb.eng_sec   = r_eng_sec;
    assign io_arb.data_o    = r_data;
    assign io_arb.valid0_o  = r_valid0;
    assign io_arb.valid1_o  = r_valid1;
    assign io_arb.err_o     = r_err;
    assign io_arb.busy_o    = (r_state != S_IDLE);
endmodule
